// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : IF stage of the 5-stage MIPS pipeline. Owns the PC, drives the
//             instruction-memory address and fills the IF/ID register with
//             the fetched instruction and PC+4. Freezes fetch on HALT.
//  Options  : MIPS_DELAY_SLOT_EN - when defined, the instruction fetched in
//             the cycle a branch is taken (the delay slot) is kept instead of
//             being squashed into a bubble.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int                    NB_ADDR    = 32,
  parameter int                    NB_INSTR   = 32,
  parameter int                    NB_COUNT   = 32,
  parameter logic [NB_INSTR-1:0]   HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_hazard,
  input  logic                 i_branch_taken,
  input  logic [NB_ADDR-1:0]   i_branch_target,
  input  logic [NB_INSTR-1:0]  i_imem_data,
  output logic [NB_ADDR-1:0]   o_imem_addr,
  output logic [NB_INSTR-1:0]  o_instr,
  output logic [NB_ADDR-1:0]   o_pc_plus4,
  output logic                 o_instr_valid,
  output logic                 o_halted,
  output logic [NB_COUNT-1:0]  o_instr_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [NB_ADDR-1:0]  c_PC_STEP    = NB_ADDR'(4);
  localparam logic [NB_ADDR-1:0]  c_ALIGN_MASK = ~NB_ADDR'(3);
  localparam logic [NB_COUNT-1:0] c_COUNT_ONE  = NB_COUNT'(1);

  state_t                r_state;
  logic [NB_ADDR-1:0]    r_pc;
  logic [NB_INSTR-1:0]   r_instr;
  logic [NB_ADDR-1:0]    r_pc_plus4;
  logic                  r_instr_valid;
  logic                  r_halted;
  logic [NB_COUNT-1:0]   r_count;

  state_t                w_state_next;
  logic [NB_ADDR-1:0]    w_pc_next;
  logic [NB_INSTR-1:0]   w_instr_next;
  logic [NB_ADDR-1:0]    w_pc_plus4_next;
  logic                  w_instr_valid_next;
  logic                  w_halted_next;
  logic [NB_COUNT-1:0]   w_count_next;

  logic [NB_ADDR-1:0]    w_pc_plus4;
  logic                  w_is_halt;

  assign w_pc_plus4 = r_pc + c_PC_STEP;
  assign w_is_halt  = (i_imem_data == HALT_INSTR);

  // Next-state and next IF/ID contents; everything holds unless a case below updates it
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_instr_next       = r_instr;
    w_pc_plus4_next    = r_pc_plus4;
    w_instr_valid_next = r_instr_valid;
    w_halted_next      = r_halted;
    w_count_next       = r_count;

    if (i_valid) begin
      case (r_state)
        ST_HALTED: begin
          // Frozen: PC holds, bubbles flow into IF/ID, hazard/branch ignored
          w_halted_next      = 1'b1;
          w_instr_next       = '0;
          w_instr_valid_next = 1'b0;
        end
        default: begin
          if (i_hazard) begin
            // Stall: PC and IF/ID hold; a stalled branch in ID will re-assert later
          end else if (i_branch_taken) begin
            w_pc_next = i_branch_target & c_ALIGN_MASK;
`ifdef MIPS_DELAY_SLOT_EN
            // Delay slot executes: keep the instruction fetched this cycle
            w_instr_next       = i_imem_data;
            w_pc_plus4_next    = w_pc_plus4;
            w_instr_valid_next = 1'b1;
            w_count_next       = r_count + c_COUNT_ONE;
            if (w_is_halt) begin
              w_state_next = ST_HALTED;
            end
`else
            // Squash the wrong-path instruction; a HALT here never takes effect
            w_instr_next       = '0;
            w_instr_valid_next = 1'b0;
`endif
          end else begin
            w_pc_next          = w_pc_plus4;
            w_instr_next       = i_imem_data;
            w_pc_plus4_next    = w_pc_plus4;
            w_instr_valid_next = 1'b1;
            w_count_next       = r_count + c_COUNT_ONE;
            if (w_is_halt) begin
              w_state_next = ST_HALTED;
            end
          end
        end
      endcase
    end
  end

  // State and IF/ID register update with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_RUN;
      r_pc          <= '0;
      r_instr       <= '0;
      r_pc_plus4    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_pc_plus4    <= w_pc_plus4_next;
      r_instr_valid <= w_instr_valid_next;
      r_halted      <= w_halted_next;
      r_count       <= w_count_next;
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_pc_plus4    = r_pc_plus4;
  assign o_instr_valid = r_instr_valid;
  assign o_halted      = r_halted;
  assign o_instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Directed, table-driven bench for instruction_fetch. The memory
//             model returns word index + 1, optionally HALT at address 8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

`ifdef MIPS_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        vld;
  logic        haz;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] imem;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] p4;
  logic        ivalid;
  logic        halted;
  logic [31:0] cnt;
  logic        h8;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_valid        (vld),
    .i_hazard       (haz),
    .i_branch_taken (br),
    .i_branch_target(tgt),
    .i_imem_data    (imem),
    .o_imem_addr    (addr),
    .o_instr        (instr),
    .o_pc_plus4     (p4),
    .o_instr_valid  (ivalid),
    .o_halted       (halted),
    .o_instr_count  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word i holds i+1, optional HALT at byte address 8
  always_comb begin
    imem = (addr >> 2) + 32'd1;
    if (h8 && addr == 32'd8) imem = 32'hFFFFFFFF;
  end

  typedef struct {
    logic        rst, vld, haz, br, h8;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_instr, e_p4;
    logic        chk_p4, e_v, e_h;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic hz, input logic b,
                     input logic m8, input logic [31:0] t,
                     input logic [31:0] ea, input logic [31:0] ei,
                     input logic [31:0] ep, input logic cp,
                     input logic ev, input logic eh, input logic [31:0] ec);
    vec_t x;
    x.rst = r; x.vld = v; x.haz = hz; x.br = b; x.h8 = m8; x.tgt = t;
    x.e_addr = ea; x.e_instr = ei; x.e_p4 = ep; x.chk_p4 = cp;
    x.e_v = ev; x.e_h = eh; x.e_cnt = ec;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all(input int idx, input vec_t x);
    string s;
    s = $sformatf("v%0d", idx);
    chk({s, ".addr"},   addr,   x.e_addr);
    chk({s, ".instr"},  instr,  x.e_instr);
    if (x.chk_p4) chk({s, ".pc4"}, p4, x.e_p4);
    chk({s, ".valid"},  {31'd0, ivalid}, {31'd0, x.e_v});
    chk({s, ".halted"}, {31'd0, halted}, {31'd0, x.e_h});
    chk({s, ".count"},  cnt,    x.e_cnt);
  endtask

  task automatic apply(input vec_t x);
    @(negedge clk);
    rst = x.rst; vld = x.vld; haz = x.haz; br = x.br; tgt = x.tgt; h8 = x.h8;
    @(posedge clk);
    #1;
  endtask

  vec_t hv;

  initial begin
    rst = 1'b1; vld = 1'b0; haz = 1'b0; br = 1'b0; tgt = '0; h8 = 1'b0;

    //    rst vld haz br h8 tgt          addr          instr                p4          cp   v   h  cnt
    // Reset then sequential fetch
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,               32'h0,      1,   0,  0, 0);
    add(0, 1, 0, 0, 0, 32'h0,        32'h4,        32'h1,               32'h4,      1,   1,  0, 1);
    add(0, 1, 0, 0, 0, 32'h0,        32'h8,        32'h2,               32'h8,      1,   1,  0, 2);
    add(0, 1, 0, 0, 0, 32'h0,        32'hC,        32'h3,               32'hC,      1,   1,  0, 3);
    add(0, 1, 0, 0, 0, 32'h0,        32'h10,       32'h4,               32'h10,     1,   1,  0, 4);
    // Hazard stall at pc=8
    add(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,               32'h0,      1,   0,  0, 0);
    add(0, 1, 0, 0, 0, 32'h0,        32'h4,        32'h1,               32'h4,      1,   1,  0, 1);
    add(0, 1, 0, 0, 0, 32'h0,        32'h8,        32'h2,               32'h8,      1,   1,  0, 2);
    add(0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h2,               32'h8,      1,   1,  0, 2);
    add(0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h2,               32'h8,      1,   1,  0, 2);
    add(0, 1, 0, 0, 0, 32'h0,        32'hC,        32'h3,               32'hC,      1,   1,  0, 3);
    // Taken branch to misaligned 0x103 at pc=12
    add(0, 1, 0, 1, 0, 32'h103,      32'h100,      DS ? 32'h4 : 32'h0,  32'h10,     DS,  DS, 0, DS ? 4 : 3);
    // Hazard with branch: branch ignored
    add(0, 1, 1, 1, 0, 32'h200,      32'h100,      DS ? 32'h4 : 32'h0,  32'h10,     DS,  DS, 0, DS ? 4 : 3);
    add(0, 1, 0, 1, 0, 32'h200,      32'h200,      DS ? 32'h41 : 32'h0, 32'h104,    DS,  DS, 0, DS ? 5 : 3);
    add(0, 1, 0, 0, 0, 32'h0,        32'h204,      32'h81,              32'h204,    1,   1,  0, DS ? 6 : 4);
    // i_valid low freezes everything even with hazard/branch asserted
    add(0, 0, 1, 1, 0, 32'h300,      32'h204,      32'h81,              32'h204,    1,   1,  0, DS ? 6 : 4);
    // PC wrap from 0xFFFFFFFC
    add(0, 1, 0, 1, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, DS ? 32'h82 : 32'h0, 32'h208,    DS,  DS, 0, DS ? 7 : 4);
    add(0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFC, DS ? 32'h82 : 32'h0, 32'h208,    DS,  DS, 0, DS ? 7 : 4);
    add(0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h40000000,        32'h0,      1,   1,  0, DS ? 8 : 5);
    // HALT in the branch shadow at pc=8
    add(1, 1, 0, 0, 1, 32'h0,        32'h0,        32'h0,               32'h0,      1,   0,  0, 0);
    add(0, 1, 0, 0, 1, 32'h0,        32'h4,        32'h1,               32'h4,      1,   1,  0, 1);
    add(0, 1, 0, 0, 1, 32'h0,        32'h8,        32'h2,               32'h8,      1,   1,  0, 2);
    add(0, 1, 0, 1, 1, 32'h100,      32'h100,      DS ? 32'hFFFFFFFF : 32'h0, 32'hC, DS, DS, 0, DS ? 3 : 2);
    add(0, 1, 0, 0, 1, 32'h0,        DS ? 32'h100 : 32'h104, DS ? 32'h0 : 32'h41, 32'h104, !DS, !DS, DS, 3);
    // Normal HALT at pc=8
    add(1, 1, 0, 0, 1, 32'h0,        32'h0,        32'h0,               32'h0,      1,   0,  0, 0);
    add(0, 1, 0, 0, 1, 32'h0,        32'h4,        32'h1,               32'h4,      1,   1,  0, 1);
    add(0, 1, 0, 0, 1, 32'h0,        32'h8,        32'h2,               32'h8,      1,   1,  0, 2);
    add(0, 1, 0, 0, 1, 32'h0,        32'hC,        32'hFFFFFFFF,        32'hC,      1,   1,  0, 3);
    add(0, 1, 0, 0, 1, 32'h0,        32'hC,        32'h0,               32'h0,      0,   0,  1, 3);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check_all(i, vecs[i]);
    end

    // Halted for 10 more cycles; hazard and branch must be ignored
    for (int k = 0; k < 10; k++) begin
      hv.rst = 0; hv.vld = 1; hv.haz = k[0]; hv.br = k[1]; hv.h8 = 1;
      hv.tgt = 32'h400; hv.e_addr = 32'hC; hv.e_instr = 32'h0; hv.e_p4 = 32'h0;
      hv.chk_p4 = 0; hv.e_v = 0; hv.e_h = 1; hv.e_cnt = 3;
      apply(hv);
      check_all(100 + k, hv);
    end

    // Reset leaves HALTED and clears all outputs
    hv.rst = 1; hv.vld = 0; hv.haz = 0; hv.br = 0; hv.h8 = 1; hv.tgt = 0;
    hv.e_addr = 0; hv.e_instr = 0; hv.e_p4 = 0; hv.chk_p4 = 1;
    hv.e_v = 0; hv.e_h = 0; hv.e_cnt = 0;
    apply(hv);
    check_all(200, hv);

    // Fetch runs again after leaving HALTED
    hv.rst = 0; hv.vld = 1; hv.e_addr = 32'h4; hv.e_instr = 32'h1; hv.e_p4 = 32'h4;
    hv.e_v = 1; hv.e_cnt = 1;
    apply(hv);
    check_all(201, hv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory address, and registers fetched instruction plus PC+4 into the IF/ID pipeline register.
- Consumes the load-use/branch stall from the hazard unit and the branch/jump redirect resolved in ID; feeds the decode stage, which returns the rs/rt fields to the hazard unit.
- Detects the HALT instruction and freezes fetch for the debug unit.

Parameters:
- NB_ADDR, 32, PC and instruction-memory byte-address width.
- NB_INSTR, 32, instruction width.
- NB_COUNT, 32, fetched-instruction counter width.
- HALT_INSTR, 32'hFFFFFFFF, encoding that stops fetch.

Ports:
- i_clock  input  1  single clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  global step enable; 0 holds all state.
- i_hazard  input  1  stall request from hazard unit.
- i_branch_taken  input  1  ID resolved a taken branch/jump this cycle.
- i_branch_target  input  NB_ADDR  redirect address.
- i_imem_data  input  NB_INSTR  instruction at o_imem_addr, combinational read.
- o_imem_addr  output  NB_ADDR  current PC.
- o_instr  output  NB_INSTR  IF/ID instruction.
- o_pc_plus4  output  NB_ADDR  IF/ID PC+4.
- o_instr_valid  output  1  IF/ID holds a real instruction (0 = bubble/NOP).
- o_halted  output  1  fetch frozen after HALT.
- o_instr_count  output  NB_COUNT  instructions written into IF/ID with valid=1.

Behaviour:
- Reset (sync, highest priority): pc=0, o_instr=0, o_pc_plus4=0, o_instr_valid=0, o_halted=0, o_instr_count=0, state=RUN.
- o_imem_addr = pc (registered value, no combinational path from inputs).
- Priority per edge: reset > i_valid=0 (hold everything) > state HALTED > i_hazard > i_branch_taken > normal fetch.
- FSM: RUN, HALTED. RUN->HALTED when a HALT_INSTR is written into IF/ID. HALTED is left only via reset.
- RUN, normal: pc<=pc+4; o_instr<=i_imem_data; o_pc_plus4<=pc+4; o_instr_valid<=1; count+=1.
- RUN, i_hazard=1: pc and the whole IF/ID register hold. i_branch_taken is ignored that cycle, because the stalled ID branch re-asserts it. Count holds.
- RUN, i_branch_taken=1 (no hazard): pc<=i_branch_target with bits [1:0] forced to 0. IF/ID contents per the optional feature.
- HALT fetched: HALT_INSTR is latched into IF/ID with valid=1 so it drains down the pipe. Next edge pc freezes at the HALT address+4, o_halted=1.
- HALTED: pc holds. IF/ID loads NOP (0) with valid=0. Count holds. i_hazard and i_branch_taken are ignored.
- A HALT_INSTR arriving in a squashed slot (branch flush without delay slot) is not latched and does not halt.
- pc+4 and the counter wrap modulo 2^NB_ADDR and 2^NB_COUNT.
- Latency: instruction at PC appears on o_instr one edge after PC is presented.

Optional Feature:
- Macro MIPS_DELAY_SLOT_EN.
- Defined: on a taken branch the instruction currently on i_imem_data (the delay slot) is fetched normally into IF/ID (valid=1, count+=1, HALT detection applies).
- Undefined: on a taken branch IF/ID loads NOP 0 with valid=0, count holds.

Test Plan:
- Reset then 4 edges with i_valid=1, imem[i]=i+1 -> o_imem_addr 0,4,8,12,16; o_instr 1,2,3,4; o_pc_plus4 4,8,12,16; count=4.
- i_hazard=1 for 2 cycles at pc=8 -> pc stays 8, o_instr and o_pc_plus4 frozen, count unchanged. Fetch resumes from 8 afterwards.
- i_branch_taken=1 with target 0x103 at pc=12 -> next pc=0x100. Without macro: o_instr=0, valid=0. With macro: o_instr=imem[12], valid=1.
- i_hazard=1 and i_branch_taken=1 together -> branch ignored, pc holds. Branch honoured the cycle after hazard drops.
- imem[8]=0xFFFFFFFF -> o_instr=0xFFFFFFFF, valid=1. Next edge o_halted=1, pc=12 frozen, valid=0 for 10 further cycles. i_reset=1 -> all outputs back to 0.
- i_valid=0 mid-stream and pc preset to 0xFFFFFFFC -> no state change while low. After i_valid=1, pc wraps to 0.
